// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//   Shares the single register-file write port between the in-order
//   write-back stage (A) and the multi-cycle execution unit (B). Fixed
//   priority to A, with a starvation guard that forces B after STARVE_LIMIT
//   consecutive A wins. The winning write is registered onto
//   RegWrite/WriteReg/WriteData. A busy scoreboard tracks destinations
//   issued to B so decode can detect RAW/WAW hazards.
//
// Ports
//   clk, rst                    clock, async active-low reset
//   a_valid/a_reg/a_data/a_ready   write-back stage request + accept
//   b_valid/b_reg/b_data/b_ready   multi-cycle unit request + accept
//   issue_valid/issue_reg       destination issued to unit B (sets busy)
//   chk_reg1/chk_reg2/chk_busy  decode hazard probe (combinational)
//   RegWrite/WriteReg/WriteData registered register-file write port
module regfile_writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        chk_busy,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [31:0] busy_q, busy_d;
  logic [3:0]  starve_q, starve_d;
  logic        src_q;  // 1 = current output write came from B

  logic a_ok, a_grant, b_grant, xfer;
  wr_t  win;

  always_comb begin
    // A must not overtake an outstanding B result to the same register
    a_ok    = a_valid && !((a_reg != 5'd0) && busy_q[a_reg]);
    b_grant = rst && b_valid && ((starve_q == LIM) || !a_ok);
    a_grant = rst && a_ok && !b_grant;
    xfer    = a_grant || b_grant;
    win     = b_grant ? wr_t'{rd: b_reg, data: b_data}
                      : wr_t'{rd: a_reg, data: a_data};
  end

  assign a_ready  = a_grant;
  assign b_ready  = b_grant;
  assign chk_busy = busy_q[chk_reg1] | busy_q[chk_reg2];

  always_comb begin
    starve_d = starve_q;
    if (b_grant || !b_valid)
      starve_d = 4'd0;
    else if (a_grant && (starve_q != LIM))
      starve_d = starve_q + 4'd1;
  end

  // Clear on the commit edge of a B write, then set from issue so a
  // same-edge set/clear of one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (RegWrite && src_q)
      busy_d[WriteReg] = 1'b0;
    if (issue_valid)
      busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      starve_q  <= '0;
      src_q     <= 1'b0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      // x0 writes complete the handshake but never enable the write
      RegWrite <= xfer && (win.rd != 5'd0);
      if (xfer) begin
        WriteReg  <= win.rd;
        WriteData <= win.data;
        src_q     <= b_grant;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_reg, b_reg, issue_reg, chk_reg1, chk_reg2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, chk_busy, RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  regfile_writeback_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .chk_busy(chk_busy),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [31:0]   busy_m;
  int          starve_m;
  bit          rw_m, src_m;
  logic [4:0]  wreg_m;
  logic [31:0] wdata_m;
  logic [31:0] rf_obs [32];  // register file as built from DUT writes

  bit obs_ar, obs_br, obs_cb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    busy_m = '0; starve_m = 0; rw_m = 0; src_m = 0; wreg_m = '0; wdata_m = '0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, take the edge,
  // advance the model, check registered outputs, return at next negedge.
  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit bv, input logic [4:0] br, input logic [31:0] bd,
                      input bit iv, input logic [4:0] ir,
                      input logic [4:0] c1, input logic [4:0] c2);
    bit aok, bg, ag;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    issue_valid = iv; issue_reg = ir; chk_reg1 = c1; chk_reg2 = c2;
    #1;
    aok = av && !((ar != 0) && busy_m[ar]);
    bg  = bv && ((starve_m == STARVE) || !aok);
    ag  = aok && !bg;
    obs_ar = a_ready; obs_br = b_ready; obs_cb = chk_busy;
    chk("a_ready", 32'(a_ready), 32'(ag));
    chk("b_ready", 32'(b_ready), 32'(bg));
    chk("chk_busy", 32'(chk_busy), 32'(busy_m[c1] | busy_m[c2]));
    @(posedge clk);
    if (rw_m && src_m) busy_m[wreg_m] = 1'b0;
    if (iv && ir != 0) busy_m[ir] = 1'b1;
    if (bg || !bv) starve_m = 0;
    else if (ag && starve_m < STARVE) starve_m++;
    if (ag || bg) begin
      rw_m    = bg ? (br != 0) : (ar != 0);
      wreg_m  = bg ? br : ar;
      wdata_m = bg ? bd : ad;
      src_m   = bg;
    end else rw_m = 1'b0;
    #1;
    chk("RegWrite", 32'(RegWrite), 32'(rw_m));
    chk("WriteReg", 32'(WriteReg), 32'(wreg_m));
    chk("WriteData", WriteData, wdata_m);
    if (RegWrite) rf_obs[WriteReg] = WriteData;
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] c1 = 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  initial begin
    int na;
    bit bseen;
    rst = 1'b0;
    a_valid = 0; a_reg = 0; a_data = 0; b_valid = 0; b_reg = 0; b_data = 0;
    issue_valid = 0; issue_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
    for (int i = 0; i < 32; i++) rf_obs[i] = '0;
    mreset();
    @(negedge clk); @(negedge clk);
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_WriteReg", 32'(WriteReg), 32'd0);
    chk("rst_WriteData", WriteData, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // first write after reset
    step(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    chk("first_RegWrite", 32'(RegWrite), 32'd1);
    chk("first_WriteReg", 32'(WriteReg), 32'd3);

    // priority: A wins when starve count is zero
    idle();
    step(1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0, 0);
    chk("prio_a_ready", 32'(obs_ar), 32'd1);
    chk("prio_b_ready", 32'(obs_br), 32'd0);
    chk("prio_WriteReg", 32'(WriteReg), 32'd5);
    idle();

    // starvation guard: exactly STARVE A grants, then B
    na = 0; bseen = 0;
    for (int i = 0; i <= STARVE; i++) begin
      step(1, 5'(10 + i), 32'(i), 1, 20, 32'hB0B0, 0, 0, 0, 0);
      if (obs_br) bseen = 1;
      else if (obs_ar && !bseen) na++;
    end
    chk("starve_a_count", 32'(na), 32'(STARVE));
    chk("starve_b_granted", 32'(bseen), 32'd1);
    step(1, 21, 32'h21, 1, 22, 32'h22, 0, 0, 0, 0);
    chk("starve_cleared", 32'(obs_ar), 32'd1);
    idle();

    // scoreboard / WAW on register 7
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    idle(7);
    chk("sb_busy7", 32'(obs_cb), 32'd1);
    step(1, 7, 32'hA7A7, 0, 0, 0, 0, 0, 7, 0);
    chk("sb_a_blocked", 32'(obs_ar), 32'd0);
    step(1, 7, 32'hA7A7, 1, 7, 32'hDEAD, 0, 0, 7, 0);
    chk("sb_b_ready", 32'(obs_br), 32'd1);
    chk("sb_b_data", WriteData, 32'hDEAD);
    step(1, 7, 32'hA7A7, 0, 0, 0, 0, 0, 7, 0);  // commit edge of B
    chk("sb_still_blocked", 32'(obs_ar), 32'd0);
    step(1, 7, 32'hA7A7, 0, 0, 0, 0, 0, 7, 0);
    chk("sb_busy_cleared", 32'(obs_cb), 32'd0);
    chk("sb_a_accepted", 32'(obs_ar), 32'd1);
    idle(); idle();
    chk("sb_final_r7", rf_obs[7], 32'hA7A7);

    // set and clear of register 9 on the same edge
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    step(0, 0, 0, 1, 9, 32'h9999, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);  // commit edge + reissue
    idle(9);
    chk("simul_busy9", 32'(obs_cb), 32'd1);
    step(0, 0, 0, 1, 9, 32'h9A9A, 0, 0, 0, 0);
    idle(); idle();

    // register 0
    step(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_a_ready", 32'(obs_ar), 32'd1);
    chk("r0_RegWrite", 32'(RegWrite), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0);
    chk("r0_not_busy", 32'(obs_cb), 32'd0);

    // randomized traffic with hazards on a small register set
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // asynchronous reset mid-stream with a write in flight
    step(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    step(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_RegWrite", 32'(RegWrite), 32'd1);
    a_valid = 1; a_reg = 13; b_valid = 1; b_reg = 14; chk_reg1 = 12;
    #2 rst = 1'b0;
    #1;
    chk("arst_RegWrite", 32'(RegWrite), 32'd0);
    chk("arst_WriteReg", 32'(WriteReg), 32'd0);
    chk("arst_WriteData", WriteData, 32'd0);
    chk("arst_chk_busy", 32'(chk_busy), 32'd0);
    chk("arst_a_ready", 32'(a_ready), 32'd0);
    chk("arst_b_ready", 32'(b_ready), 32'd0);
    mreset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 3, 32'h11, 0, 0, 0, 0, 0, 12, 0);
    chk("post_rst_RegWrite", 32'(RegWrite), 32'd1);
    chk("post_rst_WriteReg", 32'(WriteReg), 32'd3);
    chk("post_rst_WriteData", WriteData, 32'h11);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Shares the single register-file write port between two requesters: the in-order pipeline write-back stage (port A) and the multi-cycle execution unit (port B, e.g. mult/div). It arbitrates with fixed priority plus a starvation guard and registers the winning write onto the register file's RegWrite/WriteReg/WriteData inputs. It also keeps a per-register busy scoreboard for destinations issued to unit B, so decode can detect RAW/WAW hazards.

## Interface
- STARVE_LIMIT, 4: max consecutive A grants while b_valid is held before B is forced; legal range 1..15.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- a_valid  input  1  A write request.
- a_reg  input  5  A destination register.
- a_data  input  32  A write data.
- a_ready  output  1  A accepted this cycle (combinational).
- b_valid  input  1  B write request.
- b_reg  input  5  B destination register.
- b_data  input  32  B write data.
- b_ready  output  1  B accepted this cycle (combinational).
- issue_valid  input  1  an instruction targeting issue_reg was issued to unit B.
- issue_reg  input  5  its destination register.
- chk_reg1, chk_reg2  input  5 each  decode source/dest registers to test.
- chk_busy  output  1  busy[chk_reg1] | busy[chk_reg2] (combinational).
- RegWrite  output  1  register-file write enable (registered).
- WriteReg  output  5  register-file write index (registered).
- WriteData  output  32  register-file write data (registered).

## Operation
- Transfer on a port = valid & ready at posedge. At most one of a_ready/b_ready is high per cycle; both are 0 while rst is low.
- A is blocked (a_ready=0) when a_reg != 0 and busy[a_reg]=1 (WAW with outstanding B result).
- Grant rule: if b_valid and (starve_cnt == STARVE_LIMIT or A not (a_valid & unblocked)), B is granted; else, if a_valid and unblocked, A is granted.
- starve_cnt (4 bits): +1 at each A transfer while b_valid=1, saturating at STARVE_LIMIT. Cleared on a B transfer or any cycle with b_valid=0. An A request that is blocked or absent does not increment it.
- Output stage: on a transfer, the next cycle drives RegWrite=1, WriteReg=reg, WriteData=data, and records src (A/B). With no transfer, RegWrite=0 and WriteReg/WriteData hold their previous values.
- Register 0: the handshake completes normally, but RegWrite stays 0 for that write.
- Scoreboard busy[31:0]:
  - issue_valid sets busy[issue_reg]; issue_reg 0 is ignored.
  - Cleared for WriteReg at the posedge where RegWrite=1 and src=B, i.e. the same edge the register file commits the data.
  - Set and clear of the same register on the same edge: set wins.
  - busy[0] is always 0.
- Reset (asynchronous, any time):
  - busy = 0, starve_cnt = 0, RegWrite = 0, WriteReg = 0, WriteData = 0, src = A.
  - An in-flight output write is dropped.

## Timing
- Handshake-to-RegWrite latency is 1 cycle. The register file commits on the following posedge, so data is readable 2 edges after the transfer.
- Throughput is one write per cycle, sustained.
- chk_busy and ready are combinational from the current state and inputs, with no added latency.
- busy deasserts in the cycle after the commit edge. A read issued in that cycle sees the new data.
- B is guaranteed a grant within STARVE_LIMIT+1 cycles of raising b_valid.

## Test plan
- Reset values: rst low mid-stream with RegWrite=1 → RegWrite=0, WriteReg=0, WriteData=0, chk_busy=0, a_ready=b_ready=0 immediately. After release, the first A write (a_reg=3, a_data=0x11) gives RegWrite=1, WriteReg=3 one cycle later.
- Priority: A and B both valid (a_reg=5, b_reg=6) with starve_cnt=0 → a_ready=1, b_ready=0. The next cycle shows WriteReg=5.
- Starvation: a_valid held high on distinct unblocked registers, b_valid held from cycle 0, STARVE_LIMIT=4 → A granted for 4 cycles, B granted on the 5th, then starve_cnt=0.
- Scoreboard/WAW:
  - issue_reg=7 → chk_busy=1 for chk_reg1=7.
  - a_valid with a_reg=7 → a_ready=0.
  - B writes 7 (0xDEAD) → RegWrite src B; after the commit edge chk_busy=0, A is accepted, and reg 7 is finally A's data.
- Simultaneous events: issue_valid with issue_reg=9 on the same edge that B's write to 9 commits → busy[9] stays 1.
- Register 0: A write with a_reg=0 → a_ready=1, RegWrite stays 0. issue_reg=0 → chk_busy=0 for chk_reg1=0.
